// File: rtl/nock_dispatch.sv
// nock_dispatch: takes one Nock operation at a time from traversal, starts the matching
// control_mux submodule, waits for it to finish (or time out) and returns the result.

`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 16
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 32
`endif
`ifndef MUX_TRAVERSAL
`define MUX_TRAVERSAL 3'd0
`define MUX_EXECUTE   3'd1
`define MUX_CELL      3'd2
`define MUX_INCR      3'd3
`define MUX_EQUAL     3'd4
`define MUX_EDIT      3'd5
`endif

module nock_dispatch #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int OPCODE_WIDTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [OPCODE_WIDTH-1:0]       req_opcode,
  input  logic [`MEMORY_ADDR_WIDTH-1:0] req_address,
  input  logic [`MEMORY_DATA_WIDTH-1:0] req_data,
  output logic [2:0]                    sel,
  output logic [`MEMORY_ADDR_WIDTH-1:0] module_address,
  output logic [`MEMORY_DATA_WIDTH-1:0] module_data,
  output logic                          module_start,
  input  logic                          finished,
  input  logic [3:0]                    return_sys_func,
  input  logic [3:0]                    return_state,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [3:0]                    rsp_sys_func,
  output logic [3:0]                    rsp_state,
  output logic                          rsp_error,
  output logic [1:0]                    rsp_err_code
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             dec_ok;
  logic [2:0]       dec_sel;

  always_comb begin
    dec_ok  = 1'b1;
    dec_sel = `MUX_TRAVERSAL;
    case (req_opcode)
      OPCODE_WIDTH'(2):  dec_sel = `MUX_EXECUTE;
      OPCODE_WIDTH'(3):  dec_sel = `MUX_CELL;
      OPCODE_WIDTH'(4):  dec_sel = `MUX_INCR;
      OPCODE_WIDTH'(5):  dec_sel = `MUX_EQUAL;
      OPCODE_WIDTH'(10): dec_sel = `MUX_EDIT;
      default:           dec_ok  = 1'b0;
    endcase
  end

  // sel/module_address/module_data are only rewritten on a new valid request or on the
  // return to IDLE, so the combinational control_mux sees stable inputs for the whole op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      req_ready      <= 1'b1;
      sel            <= `MUX_TRAVERSAL;
      module_address <= '0;
      module_data    <= '0;
      module_start   <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_sys_func   <= '0;
      rsp_state      <= '0;
      rsp_error      <= 1'b0;
      rsp_err_code   <= ERR_NONE;
      wait_cnt       <= '0;
    end else begin
      module_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (dec_ok) begin
              sel            <= dec_sel;
              module_address <= req_address;
              module_data    <= req_data;
              module_start   <= 1'b1;
              state          <= S_ISSUE;
            end else begin
              rsp_valid    <= 1'b1;
              rsp_error    <= 1'b1;
              rsp_err_code <= ERR_OPCODE;
              rsp_sys_func <= '0;
              rsp_state    <= '0;
              state        <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (finished) begin
            rsp_valid    <= 1'b1;
            rsp_error    <= 1'b0;
            rsp_err_code <= ERR_NONE;
            rsp_sys_func <= return_sys_func;
            rsp_state    <= return_state;
            state        <= S_RESP;
          end else if (TIMEOUT_CYCLES != 0 && wait_cnt == CNT_LAST) begin
            rsp_valid    <= 1'b1;
            rsp_error    <= 1'b1;
            rsp_err_code <= ERR_TIMEOUT;
            rsp_sys_func <= '0;
            rsp_state    <= '0;
            state        <= S_RESP;
          end else if (TIMEOUT_CYCLES != 0) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (finished) begin
              state <= S_DRAIN;
            end else begin
              sel       <= `MUX_TRAVERSAL;
              req_ready <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          // a finished level left over from this op must not complete the next one
          if (!finished) begin
            sel       <= `MUX_TRAVERSAL;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          sel       <= `MUX_TRAVERSAL;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nock_dispatch.sv
// Self-checking bench for nock_dispatch: transaction-level timing model plus a
// per-cycle compare process, directed scenarios and a randomized run.

`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 16
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 32
`endif
`ifndef MUX_TRAVERSAL
`define MUX_TRAVERSAL 3'd0
`define MUX_EXECUTE   3'd1
`define MUX_CELL      3'd2
`define MUX_INCR      3'd3
`define MUX_EQUAL     3'd4
`define MUX_EDIT      3'd5
`endif

module tb_nock_dispatch;
  localparam int T  = 8;
  localparam int AW = `MEMORY_ADDR_WIDTH;
  localparam int DW = `MEMORY_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic [3:0]    req_opcode = '0;
  logic [AW-1:0] req_address = '0;
  logic [DW-1:0] req_data = '0;
  logic          finished = 1'b0;
  logic [3:0]    return_sys_func = '0;
  logic [3:0]    return_state = '0;
  logic          rsp_ready = 1'b0;

  logic          req_ready;
  logic [2:0]    sel;
  logic [AW-1:0] module_address;
  logic [DW-1:0] module_data;
  logic          module_start;
  logic          rsp_valid;
  logic [3:0]    rsp_sys_func;
  logic [3:0]    rsp_state;
  logic          rsp_error;
  logic [1:0]    rsp_err_code;

  nock_dispatch #(.TIMEOUT_CYCLES(T), .OPCODE_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_address(req_address), .req_data(req_data),
    .sel(sel), .module_address(module_address), .module_data(module_data),
    .module_start(module_start), .finished(finished),
    .return_sys_func(return_sys_func), .return_state(return_state),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sys_func(rsp_sys_func),
    .rsp_state(rsp_state), .rsp_error(rsp_error), .rsp_err_code(rsp_err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: an op accepted at edge xfer shows start in cycle xfer, its
  // result from cycle resp_cyc, and the unit is free once the result is taken and
  // finished has been seen low.
  bit            busy = 0, hs = 0, op_ok = 0, timed_out = 0, accepted_now = 0;
  bit            check_en = 0;
  int            xfer = -100, resp_cyc = 0, fin_lo = 0, fin_hi = 0;
  logic [2:0]    m_code = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [3:0]    m_sys = '0, m_st = '0;
  int            p_n = 1, p_h = 1;
  logic [3:0]    p_sys = '0, p_st = '0;

  function automatic bit is_valid_op(input logic [3:0] op);
    return op inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd10};
  endfunction

  function automatic logic [2:0] code_of(input logic [3:0] op);
    case (op)
      4'd2:    return `MUX_EXECUTE;
      4'd3:    return `MUX_CELL;
      4'd4:    return `MUX_INCR;
      4'd5:    return `MUX_EQUAL;
      4'd10:   return `MUX_EDIT;
      default: return `MUX_TRAVERSAL;
    endcase
  endfunction

  task automatic model_edge();
    accepted_now = 0;
    if (!busy) begin
      if (req_valid) begin
        busy = 1; hs = 0; accepted_now = 1; xfer = cyc;
        op_ok = is_valid_op(req_opcode);
        if (op_ok) begin
          m_code = code_of(req_opcode); m_addr = req_address; m_data = req_data;
          m_sys = p_sys; m_st = p_st;
          timed_out = (p_n > T);
          resp_cyc  = timed_out ? xfer + T + 1 : xfer + p_n + 1;
          fin_lo    = xfer + p_n;
          fin_hi    = fin_lo + p_h;
        end else begin
          timed_out = 0; resp_cyc = xfer; fin_lo = 0; fin_hi = 0;
        end
      end
    end else if (!hs) begin
      if (cyc > resp_cyc && rsp_ready) begin
        hs = 1;
        if (!finished) busy = 0;
      end
    end else if (!finished) begin
      busy = 0;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    model_edge();
    finished = (cyc >= fin_lo) && (cyc < fin_hi);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("req_ready", 64'(req_ready), 64'(!busy));
      chk("sel", 64'(sel), 64'((busy && op_ok) ? m_code : `MUX_TRAVERSAL));
      chk("module_start", 64'(module_start), 64'(busy && op_ok && cyc == xfer));
      chk("rsp_valid", 64'(rsp_valid), 64'(busy && !hs && cyc >= resp_cyc));
      chk("module_address", 64'(module_address), 64'(m_addr));
      chk("module_data", 64'(module_data), 64'(m_data));
      if (busy && !hs && cyc >= resp_cyc) begin
        chk("rsp_error", 64'(rsp_error), 64'(!op_ok || timed_out));
        chk("rsp_err_code", 64'(rsp_err_code), 64'(!op_ok ? 2'd1 : (timed_out ? 2'd2 : 2'd0)));
        chk("rsp_sys_func", 64'(rsp_sys_func), 64'((op_ok && !timed_out) ? m_sys : 4'd0));
        chk("rsp_state", 64'(rsp_state), 64'((op_ok && !timed_out) ? m_st : 4'd0));
      end
    end
  end

  int            cap_lat, cap_starts, cap_wait;
  logic [2:0]    cap_sel;
  logic [AW-1:0] cap_addr;
  logic [3:0]    cap_sys, cap_st;
  logic          cap_err;
  logic [1:0]    cap_code;

  task automatic run_op(input logic [3:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int n, input int h, input logic [3:0] sf, input logic [3:0] st,
                        input int hold);
    int guard;
    p_n = n; p_h = (n > T) ? 0 : h; p_sys = sf; p_st = st;
    return_sys_func = sf; return_state = st;
    req_opcode = op; req_address = a; req_data = d; req_valid = 1'b1; rsp_ready = 1'b0;
    cap_wait = 0;
    do begin step(); cap_wait++; end while (!accepted_now && cap_wait < 200);
    if (!accepted_now) chk("accept_bound", 64'(0), 64'(1));
    cap_sel = sel; cap_addr = module_address; cap_starts = module_start ? 1 : 0;
    req_opcode = 4'($urandom_range(0, 15));  // offered while busy, must be ignored
    guard = 0;
    while (!rsp_valid && guard < 200) begin
      step(); guard++;
      if (module_start) cap_starts++;
    end
    if (!rsp_valid) chk("rsp_bound", 64'(0), 64'(1));
    cap_lat = cyc - xfer + 1;
    cap_sys = rsp_sys_func; cap_st = rsp_state; cap_err = rsp_error; cap_code = rsp_err_code;
    repeat (hold) step();
    rsp_ready = 1'b1;
    guard = 0;
    do begin step(); guard++; end while (!hs && guard < 200);
    if (!hs) chk("handshake_bound", 64'(0), 64'(1));
    rsp_ready = 1'b0; req_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(1));
    chk({tag, "_sel"}, 64'(sel), 64'(0));
    chk({tag, "_start"}, 64'(module_start), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_error"}, 64'(rsp_error), 64'(0));
    chk({tag, "_err_code"}, 64'(rsp_err_code), 64'(0));
    chk({tag, "_addr"}, 64'(module_address), 64'(0));
    chk({tag, "_rsp_sys"}, 64'(rsp_sys_func), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    step();
    check_en = 1;

    // opcode 4, submodule finishes 3 cycles after start
    run_op(4'd4, 16'h0010, 32'h5, 3, 1, 4'd2, 4'd7, 0);
    chk("t1_lat", 64'(cap_lat), 64'(5));
    chk("t1_starts", 64'(cap_starts), 64'(1));
    chk("t1_sel", 64'(cap_sel), 64'(3'd3));
    chk("t1_addr", 64'(cap_addr), 64'(16'h0010));
    chk("t1_sys", 64'(cap_sys), 64'(2));
    chk("t1_state", 64'(cap_st), 64'(7));
    chk("t1_err", 64'(cap_err), 64'(0));

    // bad opcode
    run_op(4'd7, 16'h0022, 32'h9, 2, 1, 4'd1, 4'd1, 0);
    chk("bad_lat", 64'(cap_lat), 64'(1));
    chk("bad_starts", 64'(cap_starts), 64'(0));
    chk("bad_sel", 64'(cap_sel), 64'(0));
    chk("bad_err", 64'(cap_err), 64'(1));
    chk("bad_code", 64'(cap_code), 64'(1));

    // hung submodule
    run_op(4'd5, 16'h0031, 32'h77, 50, 0, 4'd9, 4'd9, 0);
    chk("to_lat", 64'(cap_lat), 64'(10));
    chk("to_err", 64'(cap_err), 64'(1));
    chk("to_code", 64'(cap_code), 64'(2));
    chk("to_sys", 64'(cap_sys), 64'(0));

    // result held for 5 cycles with req_valid asserted
    run_op(4'd10, 16'h0040, 32'hABCD, 2, 1, 4'd3, 4'd4, 5);
    chk("hold_sel", 64'(cap_sel), 64'(3'd5));

    // finished on the last WAIT cycle beats the timeout; one later times out
    run_op(4'd2, 16'h0050, 32'h1, 8, 1, 4'd6, 4'd5, 0);
    chk("edge8_err", 64'(cap_err), 64'(0));
    chk("edge8_lat", 64'(cap_lat), 64'(10));
    run_op(4'd2, 16'h0051, 32'h2, 9, 1, 4'd6, 4'd5, 0);
    chk("edge9_code", 64'(cap_code), 64'(2));
    chk("edge9_lat", 64'(cap_lat), 64'(10));

    // finished stays high past the handshake, then a back-to-back opcode 3
    run_op(4'd2, 16'h0060, 32'h3, 1, 15, 4'd8, 4'd8, 0);
    run_op(4'd3, 16'h0061, 32'h4, 2, 1, 4'd5, 4'd6, 0);
    chk("drain_wait", 64'(cap_wait), 64'(15));
    chk("drain_sel", 64'(cap_sel), 64'(3'd2));
    chk("drain_state", 64'(cap_st), 64'(6));

    // reset in the middle of WAIT, then a late finished that must be ignored
    p_n = 50; p_h = 0; req_opcode = 4'd5; req_address = 16'h0070; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (3) step();
    @(negedge clk); #2;
    check_en = 0;
    rst = 1'b0;
    #1;
    chk_reset_outputs("async");
    busy = 0; hs = 0; m_addr = '0; m_data = '0;
    repeat (2) step();
    @(negedge clk);
    rst = 1'b1;
    fin_lo = cyc + 2; fin_hi = cyc + 6;
    step();
    check_en = 1;
    repeat (8) step();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (!busy) begin
        req_valid = ($urandom_range(0, 1) == 1);
        case ($urandom_range(0, 9))
          0: req_opcode = 4'd2;
          1: req_opcode = 4'd3;
          2: req_opcode = 4'd4;
          3: req_opcode = 4'd5;
          4, 5: req_opcode = 4'd10;
          default: req_opcode = 4'($urandom_range(0, 15));
        endcase
        req_address = AW'($urandom);
        req_data    = DW'($urandom);
        p_n   = $urandom_range(1, 11);
        p_h   = (p_n > T) ? 0 : $urandom_range(1, 6);
        p_sys = 4'($urandom); p_st = 4'($urandom);
        return_sys_func = p_sys; return_state = p_st;
      end else begin
        req_valid  = ($urandom_range(0, 1) == 1);
        req_opcode = 4'($urandom);
      end
      rsp_ready = ($urandom_range(0, 2) == 0);
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (40) step();
    chk("final_idle", 64'(req_ready), 64'(1));

    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nock_dispatch.md
Name: nock_dispatch

Overview:
- Sequencer directly upstream of control_mux.
- Accepts one Nock operation per request from the traversal engine and decodes its opcode into a control_mux select code.
- Drives the chosen submodule's address/data and a start pulse, then waits for that submodule's finished flag.
- Captures the returned sys_func/state, presents them to traversal as a result handshake, and times out hung submodules.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles in WAIT before abort; 0 disables timeout
OPCODE_WIDTH, 4, width of incoming Nock opcode

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
req_valid  input  1  traversal presents an operation
req_ready  output  1  dispatcher can accept
req_opcode  input  OPCODE_WIDTH  Nock opcode
req_address  input  `memory_addr_width  operand address
req_data  input  `memory_data_width  operand word
sel  output  3  control_mux select (`MUX_* codes from memory_mux.vh)
module_address  output  `memory_addr_width  to control_mux module_address
module_data  output  `memory_data_width  to control_mux module_data
module_start  output  1  one-cycle start strobe to selected submodule
finished  input  1  from control_mux
return_sys_func  input  4  from control_mux
return_state  input  4  from control_mux
rsp_valid  output  1  result available
rsp_ready  input  1  traversal accepts result
rsp_sys_func  output  4  captured return_sys_func
rsp_state  output  4  captured return_state
rsp_error  output  1  result is an error
rsp_err_code  output  2  0 none, 1 bad opcode, 2 timeout

Behaviour:
- Reset (rst=0, async): state IDLE, req_ready=1, sel=`MUX_TRAVERSAL, module_start=0, rsp_valid=0, rsp_error=0, rsp_err_code=0, address/data/rsp fields=0, timeout counter=0.
- Opcode decode:
  - 2 -> `MUX_EXECUTE
  - 3 -> `MUX_CELL
  - 4 -> `MUX_INCR
  - 5 -> `MUX_EQUAL
  - 10 -> `MUX_EDIT
  - any other -> bad opcode.
- States:
  - IDLE: req_ready=1. Transfer on req_valid&&req_ready.
    - Valid opcode: latch sel/address/data, go ISSUE.
    - Bad opcode: sel stays `MUX_TRAVERSAL, go RESP with rsp_error=1, err_code=1.
  - ISSUE: exactly one cycle, module_start=1, counter cleared, go WAIT.
  - WAIT: module_start=0, counter increments each cycle.
    - finished=1: latch return_sys_func/return_state into rsp_*, rsp_error=0, go RESP.
    - Counter reaches TIMEOUT_CYCLES-1 without finished: rsp_error=1, err_code=2, rsp fields=0, go RESP.
    - finished takes priority over timeout in the same cycle.
  - RESP: rsp_valid=1, held stable until rsp_ready=1. On the transfer cycle clear rsp_valid.
    - If finished is still 1, go DRAIN.
    - Otherwise sel=`MUX_TRAVERSAL, go IDLE.
  - DRAIN: wait for finished=0, then sel=`MUX_TRAVERSAL, go IDLE. Prevents a stale finished level from completing the next op.
- sel, module_address and module_data stay constant from ISSUE through RESP/DRAIN; control_mux is combinational and needs stable inputs.
- req_ready=0 in every state except IDLE. No pipelining: one outstanding op.
- Latency, valid op whose submodule finishes N cycles after start: rsp_valid rises N+2 cycles after the request transfer.
- Latency, bad opcode: rsp_valid the cycle after transfer.
- TIMEOUT_CYCLES=0: WAIT never times out.
- Counter width is $clog2(TIMEOUT_CYCLES+1) and must not wrap.
- Reset mid-operation: immediate return to IDLE defaults. No start pulse is emitted after reset deassertion until a new request.

Test Plan:
- Reset then req opcode=4 addr=0x10 data=0x5 -> sel=`MUX_INCR, one-cycle module_start, module_address=0x10. finished after 3 cycles with sys_func=2, state=7 -> rsp_valid, rsp_sys_func=2, rsp_state=7, rsp_error=0.
- req opcode=7 -> next cycle rsp_valid=1, rsp_error=1, err_code=1, no module_start, sel=`MUX_TRAVERSAL.
- TIMEOUT_CYCLES=8, opcode=5, finished never rises -> rsp_error=1, err_code=2 after 8 WAIT cycles.
- Hold rsp_ready=0 for 5 cycles after result -> rsp_* and sel stable. req_ready=0 throughout; req_valid ignored.
- finished held high after rsp handshake -> stays in DRAIN, req_ready=0 until finished drops, then req_ready=1 and back-to-back opcode=3 dispatch works.
- Assert rst during WAIT -> all outputs at reset values asynchronously. Late finished after deassert -> ignored, no rsp_valid.
